// File: rtl/axi_lite_arbiter_if.sv
// AXI4-Lite bus bundle between the arbiter (master) and a downstream slave.
// Ports (per modport):
//   master : drives aw*/w*/ar* payload + valids, bready, rready;
//            samples awready, wready, bvalid/bresp, arready, rvalid/rdata/rresp.
//   slave  : the mirror image of master.
interface axi_lite_arbiter_if #(
    parameter int DWIDTH = 32
) ();
    logic                  awvalid;
    logic                  awready;
    logic [DWIDTH-1:0]     awaddr;
    logic [2:0]            awprot;
    logic                  wvalid;
    logic                  wready;
    logic [DWIDTH-1:0]     wdata;
    logic [DWIDTH/8-1:0]   wstrb;
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;
    logic                  arvalid;
    logic                  arready;
    logic [DWIDTH-1:0]     araddr;
    logic [2:0]            arprot;
    logic                  rvalid;
    logic                  rready;
    logic [DWIDTH-1:0]     rdata;
    logic [1:0]            rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi_lite_arbiter.sv
// Two-requester round-robin arbiter in front of one AXI4-Lite master port.
// One transaction is in flight at a time; all AXI outputs come from registers.
// Ports:
//   clk, xrst                 clock, synchronous active-high reset
//   cmd_valid/ready/write/addr/wdata{0,1}  per-requester single-beat command
//   rsp_valid{0,1}            one-cycle completion pulse to the owner
//   rsp_rdata, rsp_resp       shared completion payload, qualified by rsp_validN
//   busy                      high whenever the arbiter is not idle
//   probe                     current FSM state, zero-extended
//   axi                       AXI4-Lite master port (interface)
module axi_lite_arbiter #(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              xrst,
    input  logic              cmd_valid0,
    output logic              cmd_ready0,
    input  logic              cmd_write0,
    input  logic [DWIDTH-1:0] cmd_addr0,
    input  logic [DWIDTH-1:0] cmd_wdata0,
    input  logic              cmd_valid1,
    output logic              cmd_ready1,
    input  logic              cmd_write1,
    input  logic [DWIDTH-1:0] cmd_addr1,
    input  logic [DWIDTH-1:0] cmd_wdata1,
    output logic              rsp_valid0,
    output logic              rsp_valid1,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              busy,
    output logic [DWIDTH-1:0] probe,
    axi_lite_arbiter_if.master axi
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_BRESP = 3'd2,
        S_READ  = 3'd3,
        S_RRESP = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t            state_r, state_s;
    logic              last_gnt_r, last_gnt_s;
    logic              owner_r, owner_s;
    logic [DWIDTH-1:0] addr_r, addr_s;
    logic [DWIDTH-1:0] wdata_r, wdata_s;
    logic              awvalid_r, awvalid_s;
    logic              wvalid_r, wvalid_s;
    logic              bready_r, bready_s;
    logic              arvalid_r, arvalid_s;
    logic              rready_r, rready_s;
    logic              aw_done_r, aw_done_s;
    logic              w_done_r, w_done_s;
    logic              rsp_valid0_r, rsp_valid0_s;
    logic              rsp_valid1_r, rsp_valid1_s;
    logic [DWIDTH-1:0] rsp_rdata_r, rsp_rdata_s;
    logic [1:0]        rsp_resp_r, rsp_resp_s;
    logic              gnt0_s, gnt1_s;
    logic              aw_hs_s, w_hs_s;
    logic              sel_write_s;

    // Next-state, grant and next-register computation.
    always_comb begin
        state_s      = state_r;
        last_gnt_s   = last_gnt_r;
        owner_s      = owner_r;
        addr_s       = addr_r;
        wdata_s      = wdata_r;
        awvalid_s    = awvalid_r;
        wvalid_s     = wvalid_r;
        bready_s     = bready_r;
        arvalid_s    = arvalid_r;
        rready_s     = rready_r;
        aw_done_s    = aw_done_r;
        w_done_s     = w_done_r;
        rsp_valid0_s = 1'b0;
        rsp_valid1_s = 1'b0;
        rsp_rdata_s  = rsp_rdata_r;
        rsp_resp_s   = rsp_resp_r;

        // On a tie the requester that did not win last time gets the bus.
        gnt0_s      = cmd_valid0 && (!cmd_valid1 || last_gnt_r);
        gnt1_s      = cmd_valid1 && (!cmd_valid0 || !last_gnt_r);
        sel_write_s = gnt1_s ? cmd_write1 : cmd_write0;
        aw_hs_s     = awvalid_r && axi.awready;
        w_hs_s      = wvalid_r && axi.wready;
        cmd_ready0  = (state_r == S_IDLE) && gnt0_s;
        cmd_ready1  = (state_r == S_IDLE) && gnt1_s;

        case (state_r)
            S_IDLE: begin
                if (gnt0_s || gnt1_s) begin
                    owner_s = gnt1_s;
                    addr_s  = gnt1_s ? cmd_addr1 : cmd_addr0;
                    wdata_s = gnt1_s ? cmd_wdata1 : cmd_wdata0;
                    if (sel_write_s) begin
                        state_s   = S_WRITE;
                        awvalid_s = 1'b1;
                        wvalid_s  = 1'b1;
                        aw_done_s = 1'b0;
                        w_done_s  = 1'b0;
                    end else begin
                        state_s   = S_READ;
                        arvalid_s = 1'b1;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_WRITE: begin
                // Address and data channels retire independently.
                if (aw_hs_s) begin
                    awvalid_s = 1'b0;
                    aw_done_s = 1'b1;
                end else begin
                    awvalid_s = awvalid_r;
                end
                if (w_hs_s) begin
                    wvalid_s = 1'b0;
                    w_done_s = 1'b1;
                end else begin
                    wvalid_s = wvalid_r;
                end
                if ((aw_done_r || aw_hs_s) && (w_done_r || w_hs_s)) begin
                    state_s   = S_BRESP;
                    bready_s  = 1'b1;
                    aw_done_s = 1'b0;
                    w_done_s  = 1'b0;
                end else begin
                    state_s = S_WRITE;
                end
            end
            S_BRESP: begin
                if (axi.bvalid && bready_r) begin
                    bready_s     = 1'b0;
                    rsp_resp_s   = axi.bresp;
                    rsp_rdata_s  = {DWIDTH{1'b0}};
                    rsp_valid0_s = !owner_r;
                    rsp_valid1_s = owner_r;
                    state_s      = S_DONE;
                end else begin
                    state_s = S_BRESP;
                end
            end
            S_READ: begin
                if (arvalid_r && axi.arready) begin
                    arvalid_s = 1'b0;
                    rready_s  = 1'b1;
                    state_s   = S_RRESP;
                end else begin
                    state_s = S_READ;
                end
            end
            S_RRESP: begin
                if (axi.rvalid && rready_r) begin
                    rready_s     = 1'b0;
                    rsp_resp_s   = axi.rresp;
                    rsp_rdata_s  = axi.rdata;
                    rsp_valid0_s = !owner_r;
                    rsp_valid1_s = owner_r;
                    state_s      = S_DONE;
                end else begin
                    state_s = S_RRESP;
                end
            end
            S_DONE: begin
                // No acceptance here: cmd_ready is only high in S_IDLE.
                last_gnt_s = owner_r;
                state_s    = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (xrst) begin
            state_r      <= S_IDLE;
            last_gnt_r   <= 1'b1;
            owner_r      <= 1'b0;
            addr_r       <= {DWIDTH{1'b0}};
            wdata_r      <= {DWIDTH{1'b0}};
            awvalid_r    <= 1'b0;
            wvalid_r     <= 1'b0;
            bready_r     <= 1'b0;
            arvalid_r    <= 1'b0;
            rready_r     <= 1'b0;
            aw_done_r    <= 1'b0;
            w_done_r     <= 1'b0;
            rsp_valid0_r <= 1'b0;
            rsp_valid1_r <= 1'b0;
            rsp_rdata_r  <= {DWIDTH{1'b0}};
            rsp_resp_r   <= 2'b00;
        end else begin
            state_r      <= state_s;
            last_gnt_r   <= last_gnt_s;
            owner_r      <= owner_s;
            addr_r       <= addr_s;
            wdata_r      <= wdata_s;
            awvalid_r    <= awvalid_s;
            wvalid_r     <= wvalid_s;
            bready_r     <= bready_s;
            arvalid_r    <= arvalid_s;
            rready_r     <= rready_s;
            aw_done_r    <= aw_done_s;
            w_done_r     <= w_done_s;
            rsp_valid0_r <= rsp_valid0_s;
            rsp_valid1_r <= rsp_valid1_s;
            rsp_rdata_r  <= rsp_rdata_s;
            rsp_resp_r   <= rsp_resp_s;
        end
    end

    assign axi.awvalid = awvalid_r;
    assign axi.awaddr  = addr_r;
    assign axi.awprot  = 3'b000;
    assign axi.wvalid  = wvalid_r;
    assign axi.wdata   = wdata_r;
    assign axi.wstrb   = {(DWIDTH/8){1'b1}};
    assign axi.bready  = bready_r;
    assign axi.arvalid = arvalid_r;
    assign axi.araddr  = addr_r;
    assign axi.arprot  = 3'b000;
    assign axi.rready  = rready_r;

    assign rsp_valid0 = rsp_valid0_r;
    assign rsp_valid1 = rsp_valid1_r;
    assign rsp_rdata  = rsp_rdata_r;
    assign rsp_resp   = rsp_resp_r;
    assign busy       = (state_r != S_IDLE);
    assign probe      = {{(DWIDTH-3){1'b0}}, state_r};

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Randomised and directed bench for axi_lite_arbiter with a transaction-level
// reference model and a configurable AXI4-Lite slave.
module tb_axi_lite_arbiter;
    localparam int DWIDTH = 32;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    logic clk = 1'b0;
    logic xrst;
    logic cmd_valid0, cmd_ready0, cmd_write0, cmd_valid1, cmd_ready1, cmd_write1;
    logic [DWIDTH-1:0] cmd_addr0, cmd_wdata0, cmd_addr1, cmd_wdata1;
    logic rsp_valid0, rsp_valid1, busy;
    logic [DWIDTH-1:0] rsp_rdata, probe;
    logic [1:0] rsp_resp;

    always #5 clk = ~clk;

    axi_lite_arbiter_if #(.DWIDTH(DWIDTH)) axi ();

    axi_lite_arbiter #(.DWIDTH(DWIDTH)) dut (
        .clk(clk), .xrst(xrst),
        .cmd_valid0(cmd_valid0), .cmd_ready0(cmd_ready0), .cmd_write0(cmd_write0),
        .cmd_addr0(cmd_addr0), .cmd_wdata0(cmd_wdata0),
        .cmd_valid1(cmd_valid1), .cmd_ready1(cmd_ready1), .cmd_write1(cmd_write1),
        .cmd_addr1(cmd_addr1), .cmd_wdata1(cmd_wdata1),
        .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .busy(busy), .probe(probe), .axi(axi)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // requesters
    cmd_t cq[2][$];
    bit   rq_valid[2];
    cmd_t rq_cmd[2];
    bit   rnd_req;

    // reference model
    bit          inflight, last_owner, exp_due;
    cmd_t        inf_cmd;
    int          inf_owner, exp_owner;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    bit          aw_pend, w_pend, ar_pend, b_pend, r_pend;

    // slave
    bit          rnd_slave, s_aw_got, s_w_got, s_ar_got;
    int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    int          d_aw, d_w, d_ar, d_b, d_r;
    logic [1:0]  s_resp;
    logic [31:0] s_rdata;

    // observation log for directed tests
    int          gnt_log[$];
    int          acc_cyc, rsp_cyc, aw_first, bready_first;
    int          aw_hi, w_hi, ar_hi, rsp_cnt0, rsp_cnt1;
    logic [31:0] seen_awaddr, seen_wdata, seen_araddr, seen_rdata;
    logic [3:0]  seen_wstrb;
    logic [1:0]  seen_resp;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_log();
        gnt_log.delete();
        acc_cyc = -100; rsp_cyc = -100; aw_first = -1; bready_first = -1;
        aw_hi = 0; w_hi = 0; ar_hi = 0; rsp_cnt0 = 0; rsp_cnt1 = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        xrst = 1'b1;
        rq_valid[0] = 1'b0; rq_valid[1] = 1'b0;
        cmd_valid0 = 1'b0; cmd_valid1 = 1'b0;
        axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
        axi.bvalid = 1'b0; axi.rvalid = 1'b0; axi.bresp = 2'b00;
        axi.rresp = 2'b00; axi.rdata = 32'h0;
        inflight = 1'b0; exp_due = 1'b0; last_owner = 1'b1;
        aw_pend = 1'b0; w_pend = 1'b0; ar_pend = 1'b0; b_pend = 1'b0; r_pend = 1'b0;
        s_aw_got = 1'b0; s_w_got = 1'b0; s_ar_got = 1'b0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        @(posedge clk);
        #1 xrst = 1'b0;
        cyc++;
    endtask

    task automatic check_reset_state(input string tag);
        #2;
        check({tag, "_valids"}, {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 5'b0);
        check({tag, "_addr"}, {axi.awaddr, axi.araddr}, 64'h0);
        check({tag, "_wdata"}, axi.wdata, 32'h0);
        check({tag, "_rsp"}, {rsp_valid0, rsp_valid1, rsp_resp}, 4'b0);
        check({tag, "_rdata"}, rsp_rdata, 32'h0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_probe"}, probe, 32'h0);
    endtask

    // One clock cycle: drive at negedge, check, then account for the handshakes
    // that the coming posedge will perform.
    task automatic cycle();
        bit acc0, acc1, aw_hs, w_hs, b_hs, ar_hs, r_hs, rdy0_exp, rdy1_exp;
        @(negedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (rq_valid[i] && rnd_req && $urandom_range(0, 15) == 0) begin
                rq_valid[i] = 1'b0;
            end else if (!rq_valid[i] && cq[i].size() > 0 && (!rnd_req || $urandom_range(0, 2) == 0)) begin
                rq_cmd[i]   = cq[i].pop_front();
                rq_valid[i] = 1'b1;
            end
        end
        cmd_valid0 = rq_valid[0]; cmd_write0 = rq_cmd[0].write;
        cmd_addr0  = rq_cmd[0].addr; cmd_wdata0 = rq_cmd[0].wdata;
        cmd_valid1 = rq_valid[1]; cmd_write1 = rq_cmd[1].write;
        cmd_addr1  = rq_cmd[1].addr; cmd_wdata1 = rq_cmd[1].wdata;

        axi.awready = axi.awvalid && (aw_cnt >= d_aw);
        axi.wready  = axi.wvalid && (w_cnt >= d_w);
        axi.arready = axi.arvalid && (ar_cnt >= d_ar);
        axi.bvalid  = s_aw_got && s_w_got && (b_cnt >= d_b);
        axi.bresp   = axi.bvalid ? s_resp : 2'($urandom_range(0, 3));
        axi.rvalid  = s_ar_got && (r_cnt >= d_r);
        axi.rresp   = axi.rvalid ? s_resp : 2'($urandom_range(0, 3));
        axi.rdata   = axi.rvalid ? s_rdata : $urandom;
        #1;

        check("rsp_valid0", rsp_valid0, exp_due && exp_owner == 0);
        check("rsp_valid1", rsp_valid1, exp_due && exp_owner == 1);
        if (rsp_valid0 || rsp_valid1) begin
            check("rsp_rdata", rsp_rdata, exp_rdata);
            check("rsp_resp", rsp_resp, exp_resp);
            seen_rdata = rsp_rdata;
            seen_resp  = rsp_resp;
        end
        check("busy", busy, inflight);
        check("probe_idle", probe == 32'h0, !inflight);
        check("awvalid", axi.awvalid, aw_pend);
        check("wvalid", axi.wvalid, w_pend);
        check("arvalid", axi.arvalid, ar_pend);
        check("bready", axi.bready, b_pend);
        check("rready", axi.rready, r_pend);
        if (axi.awvalid) check("awaddr", axi.awaddr, inf_cmd.addr);
        if (axi.wvalid) check("wdata", axi.wdata, inf_cmd.wdata);
        if (axi.wvalid) check("wstrb", axi.wstrb, 4'hF);
        if (axi.arvalid) check("araddr", axi.araddr, inf_cmd.addr);
        check("prot", {axi.awprot, axi.arprot}, 6'b0);
        rdy0_exp = !inflight && rq_valid[0] && (!rq_valid[1] || last_owner == 1'b1);
        rdy1_exp = !inflight && rq_valid[1] && (!rq_valid[0] || last_owner == 1'b0);
        check("cmd_ready0", cmd_ready0, rdy0_exp);
        check("cmd_ready1", cmd_ready1, rdy1_exp);

        if (axi.awvalid) begin aw_hi++; if (aw_first < 0) aw_first = cyc; end
        if (axi.wvalid) w_hi++;
        if (axi.arvalid) ar_hi++;
        if (axi.bready && bready_first < 0) bready_first = cyc;
        if (rsp_valid0) rsp_cnt0++;
        if (rsp_valid1) rsp_cnt1++;

        if (exp_due) begin
            last_owner = exp_owner[0];
            inflight   = 1'b0;
            exp_due    = 1'b0;
            rsp_cyc    = cyc;
        end

        b_hs = axi.bvalid && axi.bready;
        if (b_hs) begin
            b_pend = 1'b0; s_aw_got = 1'b0; s_w_got = 1'b0; b_cnt = 0;
            exp_due = 1'b1; exp_owner = inf_owner; exp_rdata = 32'h0; exp_resp = s_resp;
        end else if (s_aw_got && s_w_got && !axi.bvalid) begin
            b_cnt++;
        end
        r_hs = axi.rvalid && axi.rready;
        if (r_hs) begin
            r_pend = 1'b0; s_ar_got = 1'b0; r_cnt = 0;
            exp_due = 1'b1; exp_owner = inf_owner; exp_rdata = s_rdata; exp_resp = s_resp;
        end else if (s_ar_got && !axi.rvalid) begin
            r_cnt++;
        end
        aw_hs = axi.awvalid && axi.awready;
        w_hs  = axi.wvalid && axi.wready;
        ar_hs = axi.arvalid && axi.arready;
        if (aw_hs) begin aw_pend = 1'b0; s_aw_got = 1'b1; aw_cnt = 0; seen_awaddr = axi.awaddr; end
        else if (axi.awvalid) aw_cnt++;
        if (w_hs) begin
            w_pend = 1'b0; s_w_got = 1'b1; w_cnt = 0;
            seen_wdata = axi.wdata; seen_wstrb = axi.wstrb;
        end else if (axi.wvalid) begin
            w_cnt++;
        end
        if ((aw_hs || w_hs) && !aw_pend && !w_pend) b_pend = 1'b1;
        if (ar_hs) begin ar_pend = 1'b0; s_ar_got = 1'b1; ar_cnt = 0; r_pend = 1'b1; seen_araddr = axi.araddr; end
        else if (axi.arvalid) ar_cnt++;

        acc0 = cmd_valid0 && cmd_ready0;
        acc1 = cmd_valid1 && cmd_ready1;
        if (acc0 || acc1) begin
            check("one_grant", acc0 && acc1, 1'b0);
            check("outstanding", inflight, 1'b0);
            inf_owner = acc1 ? 1 : 0;
            inf_cmd   = rq_cmd[inf_owner];
            rq_valid[inf_owner] = 1'b0;
            inflight  = 1'b1;
            acc_cyc   = cyc;
            gnt_log.push_back(inf_owner);
            if (inf_cmd.write) begin aw_pend = 1'b1; w_pend = 1'b1; end
            else ar_pend = 1'b1;
            if (rnd_slave) begin
                d_aw = $urandom_range(0, 3); d_w = $urandom_range(0, 3); d_ar = $urandom_range(0, 3);
                d_b  = $urandom_range(0, 3); d_r = $urandom_range(0, 3);
                s_resp = 2'($urandom_range(0, 3)); s_rdata = $urandom;
            end
        end
    endtask

    task automatic run_idle(input int limit, input string tag);
        int n = 0;
        while ((cq[0].size() + cq[1].size()) != 0 || rq_valid[0] || rq_valid[1] || inflight || exp_due) begin
            if (n >= limit) begin
                check({tag, "_timeout"}, 1'b1, 1'b0);
                break;
            end
            cycle();
            n++;
        end
    endtask

    task automatic set_slave(input int aw, input int w, input int ar, input int b, input int r,
                             input logic [1:0] resp, input logic [31:0] rdata);
        rnd_slave = 1'b0;
        d_aw = aw; d_w = w; d_ar = ar; d_b = b; d_r = r; s_resp = resp; s_rdata = rdata;
    endtask

    initial begin
        cmd_t c;
        int   n;
        xrst = 1'b1;
        rnd_req = 1'b0; rnd_slave = 1'b0;
        rq_cmd[0] = '0; rq_cmd[1] = '0;
        cmd_write0 = 1'b0; cmd_addr0 = 32'h0; cmd_wdata0 = 32'h0;
        cmd_write1 = 1'b0; cmd_addr1 = 32'h0; cmd_wdata1 = 32'h0;
        set_slave(0, 0, 0, 0, 0, 2'b00, 32'h0);
        clear_log();
        do_reset();
        check_reset_state("reset");

        // write from requester 0, slave always ready
        clear_log();
        cq[0].push_back('{1'b1, 32'h0000_1000, 32'hDEAD_BEEF});
        run_idle(50, "t1");
        check("t1_awaddr", seen_awaddr, 32'h0000_1000);
        check("t1_wdata", seen_wdata, 32'hDEAD_BEEF);
        check("t1_wstrb", seen_wstrb, 4'hF);
        check("t1_aw_lat", aw_first - acc_cyc, 1);
        check("t1_rsp_lat", rsp_cyc - acc_cyc, 3);
        check("t1_rsp_resp", seen_resp, 2'b00);
        check("t1_rsp_cnt", {rsp_cnt0[7:0], rsp_cnt1[7:0]}, 16'h0100);

        // read from requester 1, arready delayed 3 cycles
        clear_log();
        set_slave(0, 0, 3, 0, 0, 2'b00, 32'h1234_5678);
        cq[1].push_back('{1'b0, 32'h0000_2004, 32'h0});
        run_idle(50, "t2");
        check("t2_araddr", seen_araddr, 32'h0000_2004);
        check("t2_ar_hold", ar_hi, 4);
        check("t2_rdata", seen_rdata, 32'h1234_5678);
        check("t2_rsp_cnt", {rsp_cnt0[7:0], rsp_cnt1[7:0]}, 16'h0001);

        // both requesters busy with three commands each
        clear_log();
        rnd_slave = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cq[0].push_back('{1'(i & 1), 32'h100 + 32'(i * 4), $urandom});
            cq[1].push_back('{1'((i + 1) & 1), 32'h200 + 32'(i * 4), $urandom});
        end
        run_idle(200, "t3");
        check("t3_count", gnt_log.size(), 6);
        for (int i = 0; i < 6; i++)
            check("t3_grant", (i < gnt_log.size()) ? gnt_log[i] : 9, i % 2);

        // awready immediate, wready delayed to c4
        clear_log();
        set_slave(0, 3, 0, 0, 0, 2'b00, 32'h0);
        cq[0].push_back('{1'b1, 32'h0000_3000, 32'hCAFE_F00D});
        run_idle(50, "t4");
        check("t4_aw_hi", aw_hi, 1);
        check("t4_w_hi", w_hi, 4);
        check("t4_bready", bready_first - acc_cyc, 5);
        check("t4_rsp_lat", rsp_cyc - acc_cyc, 6);
        check("t4_wdata", seen_wdata, 32'hCAFE_F00D);

        // read returning SLVERR
        clear_log();
        set_slave(0, 0, 1, 0, 2, 2'b10, 32'hA5A5_0001);
        cq[1].push_back('{1'b0, 32'h0000_0040, 32'h0});
        run_idle(50, "t5");
        check("t5_resp", seen_resp, 2'b10);
        check("t5_rdata", seen_rdata, 32'hA5A5_0001);
        check("t5_rsp_cnt", rsp_cnt0 + rsp_cnt1, 1);
        cycle();
        check("t5_idle_probe", probe, 32'h0);

        // reset while waiting for the write response
        clear_log();
        set_slave(0, 0, 0, 8, 0, 2'b00, 32'h0);
        cq[1].push_back('{1'b1, 32'h0000_5000, 32'h5555_AAAA});
        n = 0;
        while (!axi.bready && n < 20) begin cycle(); n++; end
        check("t6_reached_bresp", axi.bready, 1'b1);
        do_reset();
        check_reset_state("t6_reset");
        clear_log();
        set_slave(0, 0, 0, 0, 0, 2'b01, 32'h7777_0000);
        cq[0].push_back('{1'b0, 32'h0000_6000, 32'h0});
        cq[1].push_back('{1'b0, 32'h0000_7000, 32'h0});
        run_idle(80, "t6");
        check("t6_first_grant", (gnt_log.size() > 0) ? gnt_log[0] : 9, 0);

        // randomised traffic
        rnd_slave = 1'b1;
        rnd_req   = 1'b1;
        for (int i = 0; i < 80; i++) begin
            c.write = 1'($urandom_range(0, 1));
            c.addr  = $urandom & 32'hFFFF_FFFC;
            c.wdata = $urandom;
            cq[i % 2].push_back(c);
        end
        run_idle(5000, "rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axi_lite_arbiter.md
Name: axi_lite_arbiter

Overview:
- Shares one AXI4-Lite master port between two independent requesters (e.g. two m_axi_lite-style test/user engines) in the same clock domain.
- Each requester issues single-beat read or write commands on a simple valid/ready command port and gets a one-cycle response pulse back.
- Round-robin grant, one outstanding transaction at a time, fully registered AXI outputs.

Parameters:
- DWIDTH, 32, AXI address/data width; wstrb width is DWIDTH/8.

Ports:
- clk  in  1  clock.
- xrst  in  1  synchronous, active-high reset.
- cmd_valid0 / cmd_valid1  in  1  requester command valid.
- cmd_ready0 / cmd_ready1  out  1  command accepted (combinational).
- cmd_write0 / cmd_write1  in  1  1 = write, 0 = read.
- cmd_addr0 / cmd_addr1  in  DWIDTH  byte address.
- cmd_wdata0 / cmd_wdata1  in  DWIDTH  write data, ignored for reads.
- rsp_valid0 / rsp_valid1  out  1  one-cycle completion pulse.
- rsp_rdata  out  DWIDTH  read data of the completed read; 0 for writes. Shared bus, qualified by rsp_validN.
- rsp_resp  out  2  captured bresp/rresp, qualified by rsp_validN.
- busy  out  1  high in any state other than S_IDLE.
- probe  out  DWIDTH  {zeros, r_state[2:0]}.
- AXI-Lite master port, as in m_axi_lite:
  - awvalid/awready/awaddr[DWIDTH]/awprot[3]
  - wvalid/wready/wdata[DWIDTH]/wstrb[DWIDTH/8]
  - bvalid/bready/bresp[2]
  - arvalid/arready/araddr[DWIDTH]/arprot[3]
  - rvalid/rready/rdata[DWIDTH]/rresp[2]

Behaviour:
- Reset (xrst high at a clock edge, including mid-transaction):
  - state S_IDLE.
  - All AXI valid/ready outputs 0; addr/data registers 0.
  - rsp_validN 0, rsp_rdata 0, rsp_resp 0.
  - r_last_gnt = 1, so requester 0 wins the first tie.
- Constant outputs: awprot = arprot = 3'b000; wstrb all ones.
- Grant, in S_IDLE:
  - Only one requester valid: that one is granted.
  - Both valid: the requester other than r_last_gnt is granted.
  - cmd_readyN = (state == S_IDLE) && granted N. Low in every other state.
- Accept (cmd_validN && cmd_readyN):
  - Latch addr/wdata/write and owner.
  - Write: next state S_WRITE; awvalid = wvalid = 1 and awaddr/wdata driven from the next cycle.
  - Read: next state S_READ; arvalid = 1 and araddr driven from the next cycle.
- S_WRITE:
  - awvalid drops the cycle after the awready handshake; wvalid drops the cycle after the wready handshake. The two are independent and may complete in either order or together.
  - When both have completed (tracked by done flags), go to S_BRESP with bready = 1.
- S_BRESP: bready held high until bvalid. On bvalid && bready, capture bresp, bready <= 0, go to S_DONE.
- S_READ: arvalid held until arready; then arvalid <= 0, rready <= 1, go to S_RRESP.
- S_RRESP: on rvalid && rready, capture rdata and rresp, rready <= 0, go to S_DONE.
- S_DONE, single cycle:
  - rsp_valid(owner) = 1 for exactly one cycle, with rsp_rdata/rsp_resp valid.
  - r_last_gnt <= owner; go to S_IDLE.
  - rsp_rdata/rsp_resp hold until the next completion.
- AXI rules:
  - Never drop a valid before its handshake.
  - Never assert valid combinationally from ready.
  - bvalid/rvalid arriving while bready/rready is low are ignored (no state change).
- Minimum latency with slave ready always high, accept at cycle 0:
  - Write: aw/w handshake at c1, b handshake at c2, rsp_valid at c3.
  - Read: ar at c1, r at c2, rsp_valid at c3.
- Corner cases:
  - cmd_valid withdrawn before ready: nothing captured.
  - A new command is never accepted in the same cycle as S_DONE; earliest acceptance is the following cycle.
  - SLVERR/DECERR are passed through in rsp_resp; the transaction completes normally.

Test Plan:
- Reset, requester 0 write to 0x1000 data 0xDEADBEEF, slave always ready, bresp=00:
  - aw/w valid at c1 with awaddr 0x1000, wdata 0xDEADBEEF, wstrb 4'hF.
  - rsp_valid0 at c3, rsp_resp 00; rsp_valid1 never asserted.
- Requester 1 read of 0x2004, arready delayed 3 cycles, rdata 0x12345678, rresp 00:
  - arvalid held stable for 4 cycles.
  - rsp_valid1 pulse with rsp_rdata 0x12345678.
- Both requesters hold valid continuously with 3 commands each:
  - Grant order 0,1,0,1,0,1.
  - Never more than one AXI transaction outstanding.
- Write with awready at c1 but wready delayed to c4:
  - awvalid low from c2, wvalid high through c4.
  - bready rises only after c4; completes correctly.
- Read returning rresp=2'b10: rsp_resp 2'b10, rsp_valid pulses once, arbiter returns to S_IDLE.
- Assert xrst for 1 cycle while in S_BRESP:
  - All valid/ready outputs 0 the next cycle, probe 0.
  - A subsequent tie grants requester 0.
